// File: rtl/cordic_pkg.sv
// Shared types and arctan constants for the CORDIC vectoring engine.
// The table is stored at 24-bit angle resolution and rounded down to WIDTH.
package cordic_pkg;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    // round(atan(2^-i) / 2pi * 2^24)
    localparam logic [23:0] ATAN24 [0:15] = '{
        24'h200000, 24'h12E405, 24'h09FB38, 24'h051112,
        24'h028B0D, 24'h0145D8, 24'h00A2F6, 24'h00517C,
        24'h0028BE, 24'h00145F, 24'h000A30, 24'h000518,
        24'h00028C, 24'h000146, 24'h0000A3, 24'h000051
    };

    function automatic logic [23:0] atan_lut(input logic [3:0] i, input int width);
        logic [24:0] v;
        int          sh;
        sh = 24 - width;
        v  = {1'b0, ATAN24[i]};
        if (sh > 0) v = (v + (25'd1 << (sh - 1))) >> sh;
        return v[23:0];
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctan lookup for the current micro-rotation index.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic [3:0]       iter,
    output logic [WIDTH-1:0] atan_i
);

    logic [23:0] full;

    always_comb begin
        full   = atan_lut(iter, WIDTH);
        atan_i = full[WIDTH-1:0];
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative CORDIC vectoring engine: atan2(sin, cos) and scaled magnitude,
// one micro-rotation per cycle after a quadrant pre-rotation on load.
module cordic_vec
    import cordic_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int ITERS = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] sin_in,
    input  logic [WIDTH-1:0] cos_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] angle,
    output logic [WIDTH-1:0] mag,
    output logic             busy
);

    localparam int XW = WIDTH + 2;
    localparam logic [WIDTH-1:0]     QUARTER = WIDTH'(1 << (WIDTH - 2));
    localparam logic signed [XW-1:0] MAG_MAX = XW'((1 << (WIDTH - 1)) - 1);

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0]        z_q, z_d;
    logic [3:0]              iter_q, iter_d;
    logic [WIDTH-1:0]        angle_q, angle_d, mag_q, mag_d;

    logic [WIDTH-1:0]        atan_i;
    logic signed [XW-1:0]    cos_x, sin_x, x_sh, y_sh, x_rot, y_rot, x_half;
    logic [WIDTH-1:0]        z_rot, mag_sat;
    logic                    last_iter;

    cordic_atan_rom #(.WIDTH(WIDTH)) u_atan (
        .iter   (iter_q),
        .atan_i (atan_i)
    );

    always_comb begin
        cos_x = {{2{cos_in[WIDTH-1]}}, cos_in};
        sin_x = {{2{sin_in[WIDTH-1]}}, sin_in};
        x_sh  = x_q >>> iter_q;
        y_sh  = y_q >>> iter_q;
        if (!y_q[XW-1]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_i;
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_i;
        end
        // Magnitude comes from the final rotation, so it is ready on the DONE edge.
        x_half = x_rot >>> 1;
        if (x_rot[XW-1])           mag_sat = '0;
        else if (x_half > MAG_MAX) mag_sat = MAG_MAX[WIDTH-1:0];
        else                       mag_sat = x_half[WIDTH-1:0];
        last_iter = (iter_q == 4'(ITERS - 1));
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start_valid) begin
                    state_d = ITER;
                    iter_d  = '0;
                    if (!cos_in[WIDTH-1]) begin
                        x_d = cos_x;  y_d = sin_x;  z_d = '0;
                    end else if (!sin_in[WIDTH-1]) begin
                        x_d = sin_x;  y_d = -cos_x; z_d = QUARTER;
                    end else begin
                        x_d = -sin_x; y_d = cos_x;  z_d = -QUARTER;
                    end
                end
                ITER: begin
                    x_d    = x_rot;
                    y_d    = y_rot;
                    z_d    = z_rot;
                    iter_d = iter_q + 4'd1;
                    if (last_iter) begin
                        state_d = DONE;
                        angle_d = z_rot;
                        mag_d   = mag_sat;
                    end
                end
                DONE: if (res_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == ITER);
    assign res_valid   = (state_q == DONE);
    assign angle       = angle_q;
    assign mag         = mag_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Directed bench for cordic_vec at WIDTH=12, ITERS=11.
module tb_cordic_vec;

    localparam int WIDTH = 12;
    localparam int ITERS = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             abort;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] sin_in, cos_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] angle, mag;
    logic             busy;

    int checks = 0;
    int passes = 0;

    cordic_vec #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort       (abort),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .sin_in      (sin_in),
        .cos_in      (cos_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .angle       (angle),
        .mag         (mag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Tolerance compare modulo 2^WIDTH so angles near +-180 deg compare sanely.
    task automatic chk_near(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp, input int tol);
        logic signed [WIDTH-1:0] d;
        int di;
        d  = obs - exp;
        di = int'(d);
        checks++;
        assert (di <= tol && di >= -tol) passes++;
        else $error("FAIL %s: got %0h expected %0h +-%0d", tag, obs, exp, tol);
    endtask

    task automatic accept(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        @(negedge clk);
        sin_in = s; cos_in = c; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                          input logic [WIDTH-1:0] exp_ang, input logic [WIDTH-1:0] exp_mag,
                          input int mag_tol, input bit check_mag);
        int lat;
        accept(s, c);
        wait_result(lat);
        chk({tag, "_valid"}, int'(res_valid), 1);
        chk_near({tag, "_angle"}, angle, exp_ang, 2);
        if (check_mag) chk_near({tag, "_mag"}, mag, exp_mag, mag_tol);
        release_res();
        chk({tag, "_released"}, int'(res_valid), 0);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] a_hold, m_hold;
        bit seen;

        rst_n = 1'b0; abort = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        sin_in = '0; cos_in = '0;
        #12;
        chk("rst_start_ready", int'(start_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_angle", int'(angle), 0);
        chk("rst_mag", int'(mag), 0);
        @(negedge clk) rst_n = 1'b1;

        // First op: latency and busy/ready decode
        accept(12'h000, 12'h400);
        chk("op0_busy", int'(busy), 1);
        chk("op0_start_ready", int'(start_ready), 0);
        wait_result(lat);
        chk("op0_latency", lat, ITERS);
        chk("op0_valid", int'(res_valid), 1);
        chk_near("op0_angle", angle, 12'h000, 2);
        chk_near("op0_mag", mag, 12'h34B, 4);
        release_res();
        chk("op0_released", int'(res_valid), 0);
        chk("op0_idle_ready", int'(start_ready), 1);

        run_op("op45", 12'h400, 12'h400, 12'h200, 12'h4A8, 4, 1'b1);
        run_op("op180", 12'h000, 12'h800, 12'h800, 12'h696, 4, 1'b1);
        run_op("opm135", 12'hC00, 12'hC00, 12'hA00, 12'h000, 0, 1'b0);
        // Saturated magnitude must be exact
        run_op("opsat", 12'h7FF, 12'h7FF, 12'h200, 12'h7FF, 0, 1'b1);
        chk("opsat_mag_exact", int'(mag), 'h7FF);

        // Backpressure: result held, start_valid ignored
        accept(12'h400, 12'h400);
        wait_result(lat);
        chk("hold_valid", int'(res_valid), 1);
        a_hold = angle; m_hold = mag;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sin_in = 12'h123; cos_in = 12'h456; start_valid = 1'b1;
            @(posedge clk);
            #1;
            if (!res_valid || angle !== a_hold || mag !== m_hold || start_ready || busy) seen = 1'b1;
        end
        start_valid = 1'b0;
        chk("hold_stable", int'(seen), 0);
        chk_near("hold_angle", angle, 12'h200, 2);
        release_res();
        chk("hold_no_restart", int'(busy), 0);
        chk("hold_idle", int'(start_ready), 1);

        // Abort at iteration 5
        a_hold = angle; m_hold = mag;
        accept(12'h000, 12'h400);
        repeat (5) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_idle", int'(start_ready), 1);
        chk("abort_busy", int'(busy), 0);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1 if (res_valid) seen = 1'b1;
        end
        chk("abort_no_result", int'(seen), 0);
        chk("abort_keeps_angle", int'(angle), int'(a_hold));
        chk("abort_keeps_mag", int'(mag), int'(m_hold));

        // Abort beats res_ready in DONE; outputs keep the latched result
        accept(12'h000, 12'h800);
        wait_result(lat);
        chk("abdone_valid", int'(res_valid), 1);
        a_hold = angle;
        @(negedge clk);
        abort = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; res_ready = 1'b0;
        chk("abdone_idle", int'(start_ready), 1);
        chk("abdone_angle", int'(angle), int'(a_hold));
        chk_near("abdone_angle_val", angle, 12'h800, 2);

        // Async reset mid-ITER
        accept(12'h400, 12'h400);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(start_ready), 1);
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_angle", int'(angle), 0);
        chk("arst_mag", int'(mag), 0);
        @(negedge clk) rst_n = 1'b1;

        run_op("post", 12'h400, 12'h400, 12'h200, 12'h4A8, 4, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cordic_vec.md
# cordic_vec

Iterative, parametrised CORDIC vectoring engine. It takes a corrected sine/cosine pair and returns the angle atan2(sin, cos) and a scaled magnitude. It runs without a controller: it sequences its own micro-rotations, does quadrant pre-rotation and saturates the magnitude output. Handshakes are valid/ready on both sides. It sits downstream of the offset/gain-correction datapath and replaces the controller-sequenced CORDIC steps in that datapath.

## Interface
- WIDTH, default 12: width of sin/cos/angle/magnitude; legal range 8..24.
- ITERS, default 11: number of micro-rotations; legal range 1..16 and ITERS ≤ WIDTH.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- abort  in  1  synchronous cancel; returns to IDLE and discards the result.
- start_valid  in  1  operands present.
- start_ready  out  1  engine can accept; high only in IDLE.
- sin_in  in  WIDTH  signed sine operand.
- cos_in  in  WIDTH  signed cosine operand.
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes the result.
- angle  out  WIDTH  signed angle; full circle = 2^WIDTH, so 0x800 means ±180° at WIDTH=12.
- mag  out  WIDTH  unsigned saturated magnitude.
- busy  out  1  high in ITER.

## Operation
- **States:**
  - IDLE: on start_valid && start_ready → ITER.
  - ITER: when iter == ITERS-1 → DONE.
  - DONE: on res_valid && res_ready → IDLE.
  - abort: any state → IDLE at the next edge; abort has priority over all other transitions.
- **Load (accept edge):** x, y are held in WIDTH+2 bits, signed; z is WIDTH bits; iter = 0.
  - cos_in ≥ 0: x = cos, y = sin, z = 0.
  - cos_in < 0 and sin_in ≥ 0: x = sin, y = -cos, z = +2^(WIDTH-2).
  - cos_in < 0 and sin_in < 0: x = -sin, y = cos, z = -2^(WIDTH-2).
- **Micro-rotation i (one per ITER cycle):**
  - y ≥ 0: x += y>>>i, y -= x>>>i, z += atan_i.
  - y < 0: x -= y>>>i, y += x>>>i, z -= atan_i.
  - All right-hand sides use the pre-update x and y. Shifts are arithmetic.
- **Angle:** z wraps modulo 2^WIDTH and is never saturated. An input of exactly 180° yields -2^(WIDTH-1).
- **Magnitude:** mag = x>>>1 (≈0.8234×|v|, since the CORDIC gain is 1.6468), clamped to 2^(WIDTH-1)-1. A negative x yields 0.
- **Arctan table:** atan_i = round(atan(2^-i)/2π × 2^WIDTH). At WIDTH=12: 200,12E,0A0,051,029,014,00A,005,003,001,001 (hex).
- **Output registers:** angle and mag are registered on the edge that enters DONE. They are held stable until the handshake completes, and they keep the last result in IDLE.
- **Flow control:**
  - start_valid outside IDLE is ignored.
  - There is no same-cycle accept on result release. The next accept can occur at the earliest one cycle after DONE exits.
- **Reset values:** state IDLE, start_ready 1, res_valid 0, busy 0, angle 0, mag 0, x/y/z/iter 0.

## Timing
- Accept at edge E. res_valid rises after edge E+ITERS, so latency is ITERS cycles.
- Minimum initiation interval: ITERS+2 cycles.
- start_ready, busy and res_valid are decoded directly from the state register; there is no combinational path from inputs.
- Asynchronous reset mid-ITER or mid-DONE: outputs go to reset values immediately and the result is lost.
- abort together with res_ready in DONE: abort wins. The outcome is the same (IDLE), but angle/mag keep the latched values.

## Structure
- Package cordic_pkg holds:
  - the state enum (IDLE, ITER, DONE);
  - ATAN24[0:15], the arctan table at 2^24 per revolution;
  - function atan_lut(i, WIDTH), which returns ATAN24[i] >> (24-WIDTH) with round-half-up.
- Sub-module cordic_atan_rom (combinational; inputs iter and WIDTH, output atan_i) wraps atan_lut.
- The shifter and the add/sub logic stay in cordic_vec.

## Test plan
- WIDTH=12, ITERS=11.
  - sin=000, cos=400 → angle 000±2, mag 34B±4.
  - res_valid exactly 11 cycles after accept.
- sin=400, cos=400 → angle 200±2, mag 4A8±4.
- sin=000, cos=800 (−2048) → angle 800±2, mag 696±4.
- sin=C00, cos=C00 → angle A00±2.
- sin=7FF, cos=7FF → angle 200±2, mag 7FF (saturated).
- Handshake and cancel:
  - Hold res_ready low for 5 cycles → res_valid, angle and mag stay stable; start_valid pulses during this time are ignored.
  - abort at iteration 5 → IDLE next edge, with no res_valid.
  - rst_n low mid-ITER → all outputs reset.
  - The following operation produces the correct result.
